// File: rtl/vga_scan_if.sv
// Pixel interface between the VGA timing master and the renderers:
// scan coordinates and frame tick out, composited pixel back.
interface vga_scan_if;
  logic [8:0] row_addr;
  logic [9:0] col_addr;
  logic       fresh;
  logic       px;

  modport master (output row_addr, col_addr, fresh, input px);
  modport slave  (input row_addr, col_addr, fresh, output px);
endinterface

// File: rtl/vga_scan.sv
// VGA 640x480@60 timing master: scan counters, registered renderer addresses,
// frame tick, and latency-aligned RGB/sync outputs for the composited pixel.
module vga_scan #(
  parameter int unsigned PX_LATENCY = 1,
  parameter logic [11:0] FG_COLOR   = 12'h555,
  parameter logic [11:0] BG_COLOR   = 12'hFFF,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  vga_scan_if.master  pix,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_BEG    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_BEG    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] FRESH_END = 10'(V_ACTIVE + 1);

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [8:0]  row_q, row_d;
  logic [9:0]  col_q, col_d;
  logic        fresh_q, fresh_d;
  logic [2:0]  raw;
  logic [2:0]  tap;
  logic [2:0]  dl_q [PX_LATENCY];
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [11:0] rgb_q, rgb_d;

  // Addresses and fresh decode the next counter value so they stay
  // cycle-aligned with h_cnt/v_cnt; fresh covers v = V_ACTIVE and V_ACTIVE+1.
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
    row_d   = (v_cnt_d < V_ACT) ? v_cnt_d[8:0] : '1;
    col_d   = (h_cnt_d < H_ACT) ? h_cnt_d : '1;
    fresh_d = (v_cnt_d == V_ACT) || (v_cnt_d == FRESH_END);
  end

  always_comb begin
    raw[2] = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    raw[1] = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
    raw[0] = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
    tap    = dl_q[PX_LATENCY-1];
    // px is only looked at when the aligned active bit is set.
    rgb_d  = tap[2] ? (pix.px ? FG_COLOR : BG_COLOR) : '0;
    hs_d   = tap[1];
    vs_d   = tap[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      fresh_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      rgb_q   <= '0;
      for (int unsigned i = 0; i < PX_LATENCY; i++) begin
        dl_q[i] <= 3'b011;
      end
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      fresh_q <= fresh_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      rgb_q   <= rgb_d;
      dl_q[0] <= raw;
      for (int unsigned i = 1; i < PX_LATENCY; i++) begin
        dl_q[i] <= dl_q[i-1];
      end
    end
  end

  assign pix.row_addr = row_q;
  assign pix.col_addr = col_q;
  assign pix.fresh    = fresh_q;
  assign hs           = hs_q;
  assign vs           = vs_q;
  assign r            = rgb_q[11:8];
  assign g            = rgb_q[7:4];
  assign b            = rgb_q[3:0];

endmodule
